systolic_feeder: RTL

Operand scheduler that sits directly upstream of systolic_array. It accepts FP16 operand-vector jobs over a valid/ready stream and buffers them in a small FIFO. It issues each job to the array as a one-cycle start pulse with operands held stable, collects the per-unit results, and returns them in order on a valid/ready output stream. It performs no arithmetic; it only handles sequencing, buffering, completion tracking and timeout.

---
 rtl/systolic_feeder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder
// ---------------------------------------------------------------------------
// Operand scheduler placed directly upstream of systolic_array. It accepts
// FP16 operand-vector jobs, buffers them in a small FIFO and issues each job
// as a one-cycle start pulse. Operands stay stable while the job runs. It
// collects the per-unit results and returns them in order. No arithmetic is
// done here: the block only sequences, buffers, tracks completion and times
// out a stalled array.
//
// Handshake semantics (both streams): a transfer happens on a rising clk edge
// where valid and ready are both 1. Once asserted, valid and its payload are
// held until that transfer. ready may change at any time and never depends
// combinationally on valid.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready : job input stream; in_a/in_b operands, in_mask units
//   sa_start          : one-cycle start pulse to the array
//   sa_active_units   : active unit mask to the array
//   sa_a/sa_b         : held operands to the array
//   sa_result/sa_ready: per-unit results and result-valid flags from the array
//   out_valid/out_ready: result output stream; out_result, out_mask, out_err
//   fifo_count        : number of buffered (not yet popped) jobs
//   busy              : job in flight or jobs buffered
//   dbg_state         : current FSM state (IDLE=0 ISSUE=1 WAIT=2 DONE=3)
// ---------------------------------------------------------------------------
module systolic_feeder #(
  parameter int WIDTH          = 16,
  parameter int NUM_UNITS      = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_UNITS-1:0][WIDTH-1:0]     in_a,
  input  logic [NUM_UNITS-1:0][WIDTH-1:0]     in_b,
  input  logic [NUM_UNITS-1:0]                in_mask,
  output logic                                sa_start,
  output logic [NUM_UNITS-1:0]                sa_active_units,
  output logic [NUM_UNITS-1:0][WIDTH-1:0]     sa_a,
  output logic [NUM_UNITS-1:0][WIDTH-1:0]     sa_b,
  input  logic [NUM_UNITS-1:0][WIDTH-1:0]     sa_result,
  input  logic [NUM_UNITS-1:0]                sa_ready,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_UNITS-1:0][WIDTH-1:0]     out_result,
  output logic [NUM_UNITS-1:0]                out_mask,
  output logic                                out_err,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
  output logic                                busy,
  output logic [1:0]                          dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  // The timer only has to count up to TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;

  // Job FIFO storage
  logic [NUM_UNITS-1:0][WIDTH-1:0] fifo_a [FIFO_DEPTH];
  logic [NUM_UNITS-1:0][WIDTH-1:0] fifo_b [FIFO_DEPTH];
  logic [NUM_UNITS-1:0]            fifo_m [FIFO_DEPTH];
  logic [PW-1:0]                   wr_ptr;
  logic [PW-1:0]                   rd_ptr;
  logic [CW-1:0]                   count_next;
  logic                            push;
  logic                            pop;

  // Job registers
  logic [NUM_UNITS-1:0][WIDTH-1:0] a_q;
  logic [NUM_UNITS-1:0][WIDTH-1:0] b_q;
  logic [NUM_UNITS-1:0]            mask_q;
  logic [NUM_UNITS-1:0][WIDTH-1:0] res_q;
  logic [NUM_UNITS-1:0]            done_q;
  logic [NUM_UNITS-1:0]            prev_ready;
  logic [TW-1:0]                   timer;

  // in_ready is a register, so a full FIFO never accepts a job even when the
  // FSM pops in the same cycle.
  assign push = in_valid && in_ready;
  assign pop  = (state == S_IDLE) && (fifo_count != '0);

  always_comb begin
    count_next = fifo_count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_a[i] <= '0;
        fifo_b[i] <= '0;
        fifo_m[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_a[wr_ptr] <= in_a;
        fifo_b[wr_ptr] <= in_b;
        fifo_m[wr_ptr] <= in_mask;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= count_next;
      in_ready   <= (count_next < CW'(FIFO_DEPTH));
    end
  end

  // Sequencing FSM. Completion is edge-based on sa_ready so that a ready level
  // left over from the previous job can never be mistaken for a new result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      mask_q     <= '0;
      res_q      <= '0;
      done_q     <= '0;
      prev_ready <= '0;
      timer      <= '0;
      sa_start   <= 1'b0;
      out_valid  <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      prev_ready <= sa_ready;
      sa_start   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            a_q     <= fifo_a[rd_ptr];
            b_q     <= fifo_b[rd_ptr];
            mask_q  <= fifo_m[rd_ptr];
            res_q   <= '0;
            done_q  <= '0;
            out_err <= 1'b0;
            if (fifo_m[rd_ptr] != '0) begin
              state    <= S_ISSUE;
              sa_start <= 1'b1;
            end else begin
              // Empty job: nothing to run, report zero results.
              state <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          done_q <= '0;
          res_q  <= '0;
          timer  <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          for (int i = 0; i < NUM_UNITS; i++) begin
            if (mask_q[i] && sa_ready[i] && !prev_ready[i] && !done_q[i]) begin
              done_q[i] <= 1'b1;
              res_q[i]  <= sa_result[i];
            end
          end
          if ((done_q & mask_q) == mask_q) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            // Abort: keep whatever was captured, the rest stays zero.
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DONE: begin
          out_valid <= 1'b1;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sa_active_units = mask_q;
  assign sa_a            = a_q;
  assign sa_b            = b_q;
  assign out_result      = res_q;
  assign out_mask        = mask_q;
  assign busy            = (state != S_IDLE) || (fifo_count != '0);
  assign dbg_state       = state;

endmodule
